// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and sync/blank helpers, used by the timing generator,
// colour mapper and sprite logic.
package vga_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP          = 16;
  localparam int unsigned H_SYNC        = 96;
  localparam int unsigned H_BP          = 48;
  localparam int unsigned H_TOTAL       = H_VISIBLE_DEF + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP          = 10;
  localparam int unsigned V_SYNC        = 2;
  localparam int unsigned V_BP          = 33;
  localparam int unsigned V_TOTAL       = V_VISIBLE_DEF + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blank_n;
  } vga_ctrl_t;

  // True when pos lies in [lo, lo+len).
  function automatic logic in_window(input logic [9:0] pos, input int unsigned lo,
                                     input int unsigned len);
    return (32'(pos) >= lo) && (32'(pos) < lo + len);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Divides the system clock down to a one-cycle pixel enable and a matching VGA_CLK output.
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic pix_en_o,
  output logic vga_clk_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);

  logic [DivW-1:0] div_q, div_d;
  logic            vga_clk_q;

  always_comb begin
    div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
  end

  // VGA_CLK is high in the upper half of the divider count, which contains the pix_en cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q     <= '0;
      vga_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      vga_clk_q <= (div_d >= DivHalf);
    end
  end

  assign pix_en_o  = (div_q == DivLast);
  assign vga_clk_o = vga_clk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync/blank decode and a one-pixel output pipeline keeping RGB aligned
// with the registered sync and blank signals.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] color_R,
  input  logic [7:0] color_G,
  input  logic [7:0] color_B,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       frame_start
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  HLast  = 10'(HTotal - 1);
  localparam logic [9:0]  VLast  = 10'(VTotal - 1);

  logic       pix_en;
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  vga_ctrl_t  ctrl_raw, ctrl_q;
  logic [7:0] r_q, g_q, b_q;
  logic       frame_start_q;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .pix_en_o  (pix_en),
    .vga_clk_o (VGA_CLK)
  );

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en) begin
      if (hc_q == HLast) begin
        hc_d = '0;
        vc_d = (vc_q == VLast) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  always_comb begin
    ctrl_raw.hs_n    = !in_window(hc_q, H_VISIBLE + H_FP, H_SYNC);
    ctrl_raw.vs_n    = !in_window(vc_q, V_VISIBLE + V_FP, V_SYNC);
    ctrl_raw.blank_n = (32'(hc_q) < H_VISIBLE) && (32'(vc_q) < V_VISIBLE);
  end

  // Colour is gated with the undelayed blank so it lands zeroed alongside the delayed blank.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      ctrl_q        <= '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_start_q <= pix_en && (hc_q == HLast) && (vc_q == VLast);
      if (pix_en) begin
        ctrl_q <= ctrl_raw;
        r_q    <= ctrl_raw.blank_n ? color_R : 8'd0;
        g_q    <= ctrl_raw.blank_n ? color_G : 8'd0;
        b_q    <= ctrl_raw.blank_n ? color_B : 8'd0;
      end
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign VGA_HS      = ctrl_q.hs_n;
  assign VGA_VS      = ctrl_q.vs_n;
  assign VGA_BLANK_N = ctrl_q.blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster; expectations come from pixel-index
// arithmetic over the line/frame geometry.
module tb_vga_timing_gen;

  localparam int HV    = 16;
  localparam int VV    = 8;
  localparam int DIV   = 2;
  localparam int HT    = HV + 16 + 96 + 48;
  localparam int VT    = VV + 10 + 2 + 33;
  localparam int FRAME = HT * VT;
  localparam int HS0   = HV + 16;
  localparam int HS1   = HS0 + 96;
  localparam int VS0   = VV + 10;
  localparam int VS1   = VS0 + 2;

  logic       Clk, Reset_n;
  logic [7:0] color_R, color_G, color_B;
  logic [9:0] DrawX, DrawY;
  logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  vga_timing_gen #(
    .H_VISIBLE (HV),
    .V_VISIBLE (VV),
    .CLK_DIV   (DIV)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .color_R     (color_R),
    .color_G     (color_G),
    .color_B     (color_B),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .frame_start (frame_start)
  );

  typedef struct {
    int         pix;
    int         x;
    int         y;
    logic       hs;
    logic       vs;
    logic       bl;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         fs_cnt = 0;
  logic [7:0] prev_r, prev_g, prev_b;

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs during pixel p reflect pixel p-1; colour for pixel p is chosen here.
  task automatic push_pixel(input int p);
    exp_t e;
    int   px, py, mode;
    e.pix = p;
    e.x   = p % HT;
    e.y   = (p / HT) % VT;
    if (p == 0) begin
      e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0;
      e.r  = 8'd0; e.g  = 8'd0; e.b  = 8'd0;
    end else begin
      px   = (p - 1) % HT;
      py   = ((p - 1) / HT) % VT;
      e.hs = !(px >= HS0 && px < HS1);
      e.vs = !(py >= VS0 && py < VS1);
      e.bl = (px < HV) && (py < VV);
      e.r  = e.bl ? prev_r : 8'd0;
      e.g  = e.bl ? prev_g : 8'd0;
      e.b  = e.bl ? prev_b : 8'd0;
    end
    mode = (e.y / 2) % 3;
    case (mode)
      1: begin color_R = 8'hFF; color_G = 8'h80; color_B = 8'h01; end
      2: begin color_R = 8'(e.x); color_G = 8'($urandom); color_B = 8'($urandom); end
      default: begin color_R = 8'($urandom); color_G = 8'($urandom); color_B = 8'($urandom); end
    endcase
    prev_r = color_R;
    prev_g = color_G;
    prev_b = color_B;
    sb.push_back(e);
  endtask

  task automatic step();
    int p;
    @(posedge Clk);
    #1;
    cyc++;
    p = cyc / DIV;
    chk("vga_clk", VGA_CLK, longint'((cyc % DIV) >= DIV / 2));
    chk("frame_start", frame_start, longint'((cyc % DIV == 0) && p > 0 && p % FRAME == 0));
    if (frame_start) fs_cnt++;
    if (cyc % DIV == 0) push_pixel(p);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_drawx"}, DrawX, 0);
    chk({tag, "_drawy"}, DrawY, 0);
    chk({tag, "_vga_clk"}, VGA_CLK, 0);
    chk({tag, "_hs"}, VGA_HS, 1);
    chk({tag, "_vs"}, VGA_VS, 1);
    chk({tag, "_blank_n"}, VGA_BLANK_N, 0);
    chk({tag, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
  endtask

  // Monitor: each VGA_CLK rising edge presents one pixel; compare in the same Clk cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge VGA_CLK);
      @(negedge Clk);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=pixel_out required=none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("drawx", DrawX, e.x);
        chk("drawy", DrawY, e.y);
        chk("hs", VGA_HS, e.hs);
        chk("vs", VGA_VS, e.vs);
        chk("blank_n", VGA_BLANK_N, e.bl);
        chk("sync_n", VGA_SYNC_N, 0);
        chk("vga_r", VGA_R, e.r);
        chk("vga_g", VGA_G, e.g);
        chk("vga_b", VGA_B, e.b);
      end
    end
  end

  initial begin
    int target;
    Reset_n = 1'b0;
    color_R = 8'h00;
    color_G = 8'h00;
    color_B = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_vals("por");

    @(negedge Clk);
    Reset_n = 1'b1;
    cyc     = 0;
    push_pixel(0);
    while (cyc < 2 * FRAME * DIV + 1) step();
    chk("frames_seen", fs_cnt, 2);

    // Stop inside both sync pulses, then reset between Clk edges.
    target = 2 * FRAME + VS0 * HT + HS0 + 10;
    while (cyc < target * DIV + 1) step();
    chk("pre_rst_hs", VGA_HS, 0);
    chk("pre_rst_vs", VGA_VS, 0);
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge Clk);
    #1;
    check_reset_vals("hold");
    chk("sb_flush", sb.size(), 0);
    sb.delete();

    @(negedge Clk);
    Reset_n = 1'b1;
    cyc     = 0;
    fs_cnt  = 0;
    push_pixel(0);
    while (cyc < 3 * HT * DIV + 1) step();
    chk("restart_no_frame_start", fs_cnt, 0);
    @(negedge Clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
